// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/MRET sequencer that owns the CSR write port while
// recording MEPC/MCAUSE/MTVAL, then fetches MTVEC (or MEPC) and redirects fetch.
`default_nettype none

module trap_ctrl #(
  parameter int CAUSE_W     = 4,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_exc_valid,
  input  logic               i_exc_is_irq,
  input  logic [CAUSE_W-1:0] i_exc_cause,
  input  logic [31:0]        i_exc_pc,
  input  logic [31:0]        i_exc_tval,
  input  logic               i_mret,
  output logic               o_accept,
  output logic               o_busy,
  output logic               o_flush,
  output logic               o_redirect_valid,
  output logic [31:0]        o_redirect_pc,
  output logic               o_csr_own,
  output logic [11:0]        o_csr_addr,
  output logic [31:0]        o_csr_data,
  output logic [3:0]         o_csr_funct3,
  output logic               o_csr_we,
  output logic               o_csr_re,
  input  logic [31:0]        i_csr_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_EPC   = 3'd1,
    WR_CAUSE = 3'd2,
    WR_TVAL  = 3'd3,
    RD_VEC   = 3'd4,
    RD_EPC   = 3'd5,
    REDIR    = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [31:2]          pc_q;
  logic [31:0]          tval_q;
  logic [CAUSE_W-1:0]   cause_q;
  logic                 irq_q;
  logic [31:0]          target_q;
  logic [31:0]          rd_base;
  logic [31:0]          vec_target;

  assign rd_base = {i_csr_rdata[31:2], 2'b00};

  // Vectored mode only applies to interrupts; the sum wraps modulo 2^32.
  always_comb begin
    vec_target = rd_base;
    if (VECTORED_EN && irq_q && (i_csr_rdata[1:0] == 2'b01))
      vec_target = rd_base + ({{(32-CAUSE_W){1'b0}}, cause_q} << 2);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      pc_q     <= '0;
      tval_q   <= '0;
      cause_q  <= '0;
      irq_q    <= 1'b0;
      target_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && i_exc_valid) begin
        pc_q    <= i_exc_pc[31:2];
        tval_q  <= i_exc_tval;
        cause_q <= i_exc_cause;
        irq_q   <= i_exc_is_irq;
      end
      if (state == RD_VEC)
        target_q <= vec_target;
      else if (state == RD_EPC)
        target_q <= rd_base;
    end
  end

  assign o_redirect_pc = target_q;
  assign o_csr_funct3  = 4'b0001;

  always_comb begin
    state_nxt        = state;
    o_accept         = 1'b0;
    o_flush          = 1'b0;
    o_busy           = 1'b1;
    o_csr_own        = 1'b1;
    o_csr_addr       = 12'h000;
    o_csr_data       = 32'h0;
    o_csr_we         = 1'b0;
    o_csr_re         = 1'b0;
    o_redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        o_busy    = 1'b0;
        o_csr_own = 1'b0;
        // Gated by reset so the handshake drops the moment reset asserts.
        o_accept  = i_rst & (i_exc_valid | i_mret);
        o_flush   = o_accept;
        if (i_exc_valid)
          state_nxt = WR_EPC;
        else if (i_mret)
          state_nxt = RD_EPC;
      end
      WR_EPC: begin
        o_csr_addr = 12'h341;
        o_csr_data = {pc_q, 2'b00};
        o_csr_we   = 1'b1;
        state_nxt  = WR_CAUSE;
      end
      WR_CAUSE: begin
        o_csr_addr = 12'h342;
        o_csr_data = {irq_q, {(31-CAUSE_W){1'b0}}, cause_q};
        o_csr_we   = 1'b1;
        state_nxt  = WR_TVAL;
      end
      WR_TVAL: begin
        o_csr_addr = 12'h343;
        o_csr_data = tval_q;
        o_csr_we   = 1'b1;
        state_nxt  = RD_VEC;
      end
      RD_VEC: begin
        o_csr_addr = 12'h305;
        o_csr_re   = 1'b1;
        state_nxt  = REDIR;
      end
      RD_EPC: begin
        o_csr_addr = 12'h341;
        o_csr_re   = 1'b1;
        state_nxt  = REDIR;
      end
      REDIR: begin
        o_redirect_valid = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed and random traps/MRETs against a
// spec-level model of CSR contents, redirect targets and cycle timing.
`default_nettype none

module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, exc_is_irq, mret;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        accept, busy, flush, redirect_valid, csr_own, csr_we, csr_re;
  logic [31:0] redirect_pc, csr_data, csr_rdata;
  logic [11:0] csr_addr;
  logic [3:0]  csr_funct3;
  // Second instance with vectoring disabled, fed the same stimulus.
  logic        d_accept, d_busy, d_flush, d_rv, d_own, d_we, d_re;
  logic [31:0] d_rpc, d_data;
  logic [11:0] d_addr;
  logic [3:0]  d_f3;

  int errors = 0;
  int checks = 0;

  // CSR file model: DUT writes MEPC/MCAUSE/MTVAL, bench owns MTVEC.
  logic [31:0] csr_mepc = 32'h0, csr_mcause = 32'h0, csr_mtval = 32'h0, csr_mtvec = 32'h0;
  logic [31:0] last_epc = 32'h0;

  always #5 clk = ~clk;

  trap_ctrl #(.CAUSE_W(4), .VECTORED_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_exc_valid(exc_valid), .i_exc_is_irq(exc_is_irq),
    .i_exc_cause(exc_cause), .i_exc_pc(exc_pc), .i_exc_tval(exc_tval), .i_mret(mret),
    .o_accept(accept), .o_busy(busy), .o_flush(flush), .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc), .o_csr_own(csr_own), .o_csr_addr(csr_addr),
    .o_csr_data(csr_data), .o_csr_funct3(csr_funct3), .o_csr_we(csr_we),
    .o_csr_re(csr_re), .i_csr_rdata(csr_rdata));

  trap_ctrl #(.CAUSE_W(4), .VECTORED_EN(1'b0)) dut_direct (
    .i_clk(clk), .i_rst(rst), .i_exc_valid(exc_valid), .i_exc_is_irq(exc_is_irq),
    .i_exc_cause(exc_cause), .i_exc_pc(exc_pc), .i_exc_tval(exc_tval), .i_mret(mret),
    .o_accept(d_accept), .o_busy(d_busy), .o_flush(d_flush), .o_redirect_valid(d_rv),
    .o_redirect_pc(d_rpc), .o_csr_own(d_own), .o_csr_addr(d_addr),
    .o_csr_data(d_data), .o_csr_funct3(d_f3), .o_csr_we(d_we),
    .o_csr_re(d_re), .i_csr_rdata(csr_rdata));

  always_comb begin
    case (csr_addr)
      12'h341: csr_rdata = csr_mepc;
      12'h342: csr_rdata = csr_mcause;
      12'h343: csr_rdata = csr_mtval;
      12'h305: csr_rdata = csr_mtvec;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (csr_we) begin
      case (csr_addr)
        12'h341: csr_mepc   <= csr_data;
        12'h342: csr_mcause <= csr_data;
        12'h343: csr_mtval  <= csr_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic trap(input logic [31:0] pc, input logic [3:0] cause, input logic irq,
                      input logic [31:0] tval, input logic [31:0] mtvec, input logic with_mret);
    logic [31:0] e_epc, e_cause, base, e_tgt;
    e_epc   = pc & 32'hFFFF_FFFC;
    e_cause = (irq ? 32'h8000_0000 : 32'h0) + {28'd0, cause};
    base    = mtvec & 32'hFFFF_FFFC;
    e_tgt   = (irq && (mtvec[1:0] == 2'b01)) ? base + 32'd4 * {28'd0, cause} : base;
    csr_mtvec = mtvec;
    // cycle N: request
    @(negedge clk);
    exc_valid = 1'b1; exc_pc = pc; exc_cause = cause; exc_is_irq = irq; exc_tval = tval;
    mret = with_mret;
    #1;
    chk("accept_N", {31'd0, accept}, 32'd1);
    chk("flush_N", {31'd0, flush}, 32'd1);
    chk("busy_N", {31'd0, busy}, 32'd0);
    // N+1: MEPC write; stray MRET must be ignored
    @(negedge clk);
    exc_valid = 1'b0; mret = 1'($urandom_range(0, 1));
    #1;
    chk("accept_busy", {31'd0, accept}, 32'd0);
    chk("busy_N1", {31'd0, busy}, 32'd1);
    chk("own_N1", {31'd0, csr_own}, 32'd1);
    chk("we_N1", {31'd0, csr_we}, 32'd1);
    chk("addr_mepc", {20'd0, csr_addr}, 32'h341);
    chk("data_mepc", csr_data, e_epc);
    // N+2: MCAUSE
    @(negedge clk); #1;
    chk("addr_mcause", {20'd0, csr_addr}, 32'h342);
    chk("data_mcause", csr_data, e_cause);
    chk("we_N2", {31'd0, csr_we}, 32'd1);
    // N+3: MTVAL
    @(negedge clk); #1;
    chk("addr_mtval", {20'd0, csr_addr}, 32'h343);
    chk("data_mtval", csr_data, tval);
    // N+4: MTVEC read
    @(negedge clk); #1;
    chk("addr_mtvec", {20'd0, csr_addr}, 32'h305);
    chk("re_N4", {31'd0, csr_re}, 32'd1);
    chk("we_N4", {31'd0, csr_we}, 32'd0);
    chk("rv_N4", {31'd0, redirect_valid}, 32'd0);
    // N+5: redirect pulse
    @(negedge clk);
    mret = 1'b0;
    #1;
    chk("rv_N5", {31'd0, redirect_valid}, 32'd1);
    chk("rpc_N5", redirect_pc, e_tgt);
    chk("rpc_direct", d_rpc, base);
    chk("busy_N5", {31'd0, busy}, 32'd1);
    // N+6: back in IDLE
    @(negedge clk); #1;
    chk("rv_N6", {31'd0, redirect_valid}, 32'd0);
    chk("busy_N6", {31'd0, busy}, 32'd0);
    chk("rpc_hold", redirect_pc, e_tgt);
    chk("file_mepc", csr_mepc, e_epc);
    chk("file_mcause", csr_mcause, e_cause);
    chk("file_mtval", csr_mtval, tval);
    last_epc = e_epc;
  endtask

  task automatic do_mret();
    @(negedge clk);
    mret = 1'b1;
    #1;
    chk("mret_accept", {31'd0, accept}, 32'd1);
    chk("mret_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    mret = 1'b0;
    #1;
    chk("mret_addr", {20'd0, csr_addr}, 32'h341);
    chk("mret_re", {31'd0, csr_re}, 32'd1);
    chk("mret_we", {31'd0, csr_we}, 32'd0);
    @(negedge clk); #1;
    chk("mret_rv", {31'd0, redirect_valid}, 32'd1);
    chk("mret_rpc", redirect_pc, last_epc);
    @(negedge clk); #1;
    chk("mret_rv_off", {31'd0, redirect_valid}, 32'd0);
    chk("mret_busy_off", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; exc_valid = 1'b0; exc_is_irq = 1'b0; mret = 1'b0;
    exc_cause = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_own", {31'd0, csr_own}, 32'd0);
    chk("rst_we", {31'd0, csr_we}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_funct3", {28'd0, csr_funct3}, 32'h1);

    trap(32'h0000_1003, 4'd2, 1'b0, 32'hDEAD_BEEF, 32'h8000_0101, 1'b0);
    trap(32'h0000_4444, 4'd7, 1'b1, 32'h0, 32'h8000_0001, 1'b0);
    trap(32'h0000_2000, 4'd11, 1'b0, 32'h1234_5678, 32'h0000_0200, 1'b1);
    do_mret();
    // Vectored target that wraps past 2^32
    trap(32'h0000_3000, 4'd15, 1'b1, 32'h0, 32'hFFFF_FFF1, 1'b0);

    // Reset in WR_CAUSE abandons the trap
    @(negedge clk);
    exc_valid = 1'b1; exc_pc = 32'h0000_5000; exc_cause = 4'd3; exc_is_irq = 1'b0;
    exc_tval = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_rst_addr", {20'd0, csr_addr}, 32'h342);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_own", {31'd0, csr_own}, 32'd0);
    chk("mid_rst_we", {31'd0, csr_we}, 32'd0);
    chk("mid_rst_addr", {20'd0, csr_addr}, 32'h0);
    chk("mid_rst_data", csr_data, 32'h0);
    chk("mid_rst_accept", {31'd0, accept}, 32'd0);
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_rpc", redirect_pc, 32'h0);
    chk("mid_rst_funct3", {28'd0, csr_funct3}, 32'h1);
    @(negedge clk);
    exc_valid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("post_rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    chk("post_rst_mtval", csr_mtval, 32'h0);
    trap(32'h0000_6006, 4'd5, 1'b1, 32'h0, 32'h0000_1001, 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_mret();
      else
        trap($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer sitting directly upstream of the CSR register file.
- On an exception/interrupt, it drives the file's single write port to record MEPC, MCAUSE and MTVAL, then reads MTVEC and issues a PC redirect.
- On MRET, it reads MEPC and redirects to it.
- While it owns the CSR port, the pipeline is stalled. An external mux selects trap_ctrl's CSR signals whenever o_csr_own=1.

Parameters:
- CAUSE_W, 4: width of the exception/interrupt cause code.
- VECTORED_EN, 1: 1 = honour MTVEC mode 01 (vectored) for interrupts; 0 = always direct mode.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; asynchronous, active-low (0 = reset).
- i_exc_valid  input  1  exception/interrupt request from the pipeline.
- i_exc_is_irq  input  1  1 = interrupt, 0 = synchronous exception.
- i_exc_cause  input  CAUSE_W  cause code.
- i_exc_pc  input  32  PC of the faulting/interrupted instruction.
- i_exc_tval  input  32  trap value (bad address/instruction, else 0).
- i_mret  input  1  MRET retiring.
- o_accept  output  1  combinational; request taken this cycle.
- o_busy  output  1  stall the pipeline.
- o_flush  output  1  flush younger instructions.
- o_redirect_valid  output  1  one-cycle pulse; fetch must load o_redirect_pc.
- o_redirect_pc  output  32  trap target or return address.
- o_csr_own  output  1  trap_ctrl drives the CSR port.
- o_csr_addr  output  12  CSR address.
- o_csr_data  output  32  CSR write data.
- o_csr_funct3  output  4  CSR op; always 4'b0001 (CSRRW).
- o_csr_we  output  1  CSR write enable.
- o_csr_re  output  1  CSR read enable.
- i_csr_rdata  input  32  CSR file combinational read data.

Behaviour:
- Reset (i_rst=0, async): state=IDLE; all outputs 0 except o_csr_funct3=4'b0001. Captured regs cleared. Reset mid-sequence abandons the trap with no redirect and no further CSR writes.
- States: IDLE, WR_EPC, WR_CAUSE, WR_TVAL, RD_VEC, RD_EPC, REDIR.
- IDLE transitions:
  - o_accept = i_exc_valid | i_mret.
  - If i_exc_valid (wins over simultaneous i_mret): capture pc, cause, is_irq, tval; go to WR_EPC.
  - Else if i_mret: go to RD_EPC.
  - o_flush = o_accept (same cycle).
- WR_EPC: addr 12'h341, data {i_exc_pc[31:2],2'b00}, we=1. Next WR_CAUSE.
- WR_CAUSE: addr 12'h342, data {is_irq, zeros, cause} (cause zero-extended to 31 bits), we=1. Next WR_TVAL.
- WR_TVAL: addr 12'h343, data tval, we=1. Next RD_VEC.
- RD_VEC: addr 12'h305, re=1, we=0.
  - base = {rdata[31:2],2'b00}.
  - Target = base + (cause<<2) if VECTORED_EN && is_irq && rdata[1:0]==2'b01; else base.
  - Addition is 32-bit and wraps modulo 2^32.
  - Register the target; next REDIR.
- RD_EPC: addr 12'h341, re=1. Register {rdata[31:2],2'b00}; next REDIR.
- REDIR: o_redirect_valid=1 for exactly one cycle, o_redirect_pc=target. Next IDLE.
- o_busy and o_csr_own are 1 in every non-IDLE state. o_csr_we is 1 only in WR_*; o_csr_re only in RD_*. In IDLE, addr and data are 0.
- Latency: exception accepted in cycle N gives writes in N+1..N+3, MTVEC read in N+4, redirect pulse in N+5. MRET accepted in N gives read in N+1, redirect in N+2.
- Requests arriving while not in IDLE are ignored (not accepted); the pipeline is stalled and must hold them.
- A new request may be accepted in the IDLE cycle immediately following REDIR.
- o_redirect_pc holds its last value outside REDIR.

Test Plan:
- Reset then idle: i_rst=0 mid-cycle -> all outputs 0 immediately; after release, o_busy=0, no CSR writes.
- Exception: pc=0x0000_1003, cause=2, irq=0, tval=0xDEAD_BEEF, MTVEC=0x8000_0101.
  - Expect writes MEPC=0x0000_1000, MCAUSE=0x0000_0002, MTVAL=0xDEAD_BEEF in cycles N+1..N+3.
  - Expect redirect 0x8000_0100 at N+5; o_busy high N+1..N+5.
- Vectored interrupt: irq=1, cause=7, MTVEC=0x8000_0001 -> MCAUSE=0x8000_0007, redirect 0x8000_001C. Same case with VECTORED_EN=0 -> redirect 0x8000_0000.
- MRET: MEPC=0x0000_2000 -> o_accept and o_flush at N, read at N+1, redirect 0x0000_2000 at N+2 with a single-cycle pulse.
- Simultaneous i_exc_valid and i_mret -> exception path taken, MEPC written. i_mret asserted during busy -> not accepted, no second redirect.
- Reset asserted in WR_CAUSE -> no MTVAL write, no redirect; state returns to IDLE and the next exception sequences normally.
